// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states and
// protocol field widths.
package spi_flash_responder_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_e;

  function automatic logic is_supported_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_FAST_READ);
  endfunction

endpackage

// File: rtl/spi_flash_responder_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI-flash target answering READ / FAST_READ from an internal byte array that
// is preloaded through a host write port. All SPI pins are oversampled in pclk.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int MEM_BYTES   = 6144,
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              bad_cmd,
  output logic [7:0]        last_cmd
);

  localparam int PTR_W = $clog2(MEM_BYTES);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i  (pclk),
    .rst_i  (reset),
    .pin_i  (spi_sclk),
    .level_o(sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk_i  (pclk),
    .rst_i  (reset),
    .pin_i  (spi_cs_n),
    .level_o(cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i  (pclk),
    .rst_i  (reset),
    .pin_i  (spi_mosi),
    .level_o(mosi_s),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  assign unused_edges = ^{sclk_s, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_e            state_q;
  logic [4:0]        bit_cnt_q;
  logic [ADDR_W-1:0] shift_q;
  logic              fast_q;
  logic [PTR_W-1:0]  ptr_q;
  logic              fetch_q;
  logic              miso_q;
  logic              bad_cmd_q;
  logic [7:0]        last_cmd_q;
  logic              armed_q;
  logic [SYNC_STAGES:0] settle_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem_q [MEM_BYTES];

  logic [ADDR_W-1:0] shift_d;
  logic [7:0]        opcode_d;
  logic [PTR_W-1:0]  addr_ptr_d;
  logic [PTR_W-1:0]  ptr_inc_d;
  logic [PTR_W-1:0]  load_idx_d;
  logic              settled_d;

  assign shift_d    = {shift_q[ADDR_W-2:0], mosi_s};
  assign opcode_d   = shift_d[7:0];
  assign addr_ptr_d = PTR_W'(shift_d % ADDR_W'(MEM_BYTES));
  assign ptr_inc_d  = (ptr_q == PTR_W'(MEM_BYTES - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign load_idx_d = PTR_W'(load_addr % ADDR_W'(MEM_BYTES));
  assign settled_d  = settle_q[SYNC_STAGES];

  // The synchronizer comes out of reset showing cs_n high, so arming waits until
  // it holds real samples; a select held low across reset is then ignored
  // until the controller deasserts it.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      settle_q <= '0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      fast_q     <= 1'b0;
      ptr_q      <= '0;
      fetch_q    <= 1'b0;
      miso_q     <= 1'b0;
      bad_cmd_q  <= 1'b0;
      last_cmd_q <= 8'h00;
      armed_q    <= 1'b0;
    end else begin
      bad_cmd_q <= 1'b0;
      fetch_q   <= 1'b0;
      if (cs_n_s) begin
        state_q   <= S_IDLE;
        miso_q    <= 1'b0;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        armed_q   <= armed_q | settled_d;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (armed_q) begin
              state_q   <= S_CMD;
              bit_cnt_q <= '0;
              shift_q   <= '0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                bit_cnt_q  <= '0;
                last_cmd_q <= opcode_d;
                if (is_supported_op(opcode_d)) begin
                  state_q <= S_ADDR;
                  fast_q  <= (opcode_d == OP_FAST_READ);
                end else begin
                  bad_cmd_q <= 1'b1;
                  state_q   <= S_IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              shift_q <= shift_d;
              if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                bit_cnt_q <= '0;
                ptr_q     <= addr_ptr_d;
                fetch_q   <= 1'b1;
                state_q   <= fast_q ? S_DUMMY : S_DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          S_DUMMY: begin
            if (sclk_rise) begin
              if (bit_cnt_q == 5'(DUMMY_BITS - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= S_DATA;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          S_DATA: begin
            // Bit index counts up while the byte is sent MSB first.
            if (sclk_fall) begin
              miso_q <= rd_data_q[~bit_cnt_q[2:0]];
              if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
                bit_cnt_q <= '0;
                ptr_q     <= ptr_inc_d;
                fetch_q   <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end
          S_IGNORE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            miso_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read-before-write: a fetch colliding with a load returns the old byte.
  always_ff @(posedge pclk) begin
    if (load_we) begin
      mem_q[load_idx_d] <= load_data;
    end
    if (fetch_q) begin
      rd_data_q <= mem_q[ptr_q];
    end
  end

  assign spi_miso = miso_q;
  assign busy     = ~cs_n_s;
  assign bad_cmd  = bad_cmd_q;
  assign last_cmd = last_cmd_q;

endmodule
